// File: rtl/proc_pkg.sv
// Shared processor types and constants.
// Imported by the fetch stage and its queue.
package proc_pkg;

  localparam int XLEN    = 32;
  localparam int INSTR_W = 32;

  localparam logic [XLEN-1:0] PC_STEP = 32'd4;

  typedef enum logic {
    FETCH_RUN,
    FETCH_FLUSH
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch queue of {pc, instruction} entries.
// Outputs come straight from storage; no write-to-read bypass.
module fetch_fifo
  import proc_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               wr_en,
  input  logic [XLEN-1:0]    wr_pc,
  input  logic [INSTR_W-1:0] wr_instr,
  input  logic               rd_en,
  output logic               rd_valid,
  output logic [XLEN-1:0]    rd_pc,
  output logic [INSTR_W-1:0] rd_instr,
  output logic [CW-1:0]      count
);

  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_wr;
  logic          do_rd;

  assign rd_valid = (count != '0);
  assign do_rd    = rd_en & rd_valid & ~clear;
  assign do_wr    = wr_en & ~clear &
                    ((count != FULL) | do_rd);

  // Idle outputs read as zero so nothing stale leaks out
  assign rd_pc    = rd_valid ? mem[rd_ptr].pc    : '0;
  assign rd_instr = rd_valid ? mem[rd_ptr].instr : '0;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_wr) - CW'(do_rd);
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr] <= '{pc: wr_pc, instr: wr_instr};
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: credit-limited requests, in-order prefetch.
// Optional perf counters under INSTR_FETCH_PERF_EN.
module instr_fetch
  import proc_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instruction,
  output logic [31:0] instr_pc
`ifdef INSTR_FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetch_count,
  output logic [31:0] perf_flush_count
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0] LIMIT = (CW + 1)'(DEPTH);

  fetch_state_t    state;
  fetch_state_t    state_n;
  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] fetch_pc_n;
  logic [XLEN-1:0] rsp_pc;
  logic [XLEN-1:0] rsp_pc_n;
  logic [XLEN-1:0] target;
  logic [CW-1:0]   outst;
  logic [CW-1:0]   outst_n;
  logic [CW-1:0]   discard;
  logic [CW-1:0]   discard_n;
  logic [CW-1:0]   occ;
  logic [CW:0]     in_use;
  logic            req_fire;
  logic            rsp_wr;
  logic            deliver;

  assign target   = redirect_pc & 32'hFFFF_FFFC;
  assign in_use   = {1'b0, occ} + {1'b0, outst};
  assign req_fire = imem_req_valid & imem_req_ready;
  assign deliver  = instr_valid & instr_ready;

  assign imem_req_addr  = fetch_pc;
  assign imem_req_valid = ~reset & (state == FETCH_RUN) &
                          (in_use < LIMIT) & ~redirect_valid;

  assign rsp_wr = imem_rsp_valid & (state == FETCH_RUN) &
                  ~redirect_valid;

  always_comb begin
    state_n    = state;
    fetch_pc_n = fetch_pc;
    rsp_pc_n   = rsp_pc;
    discard_n  = discard;
    outst_n    = outst + CW'(req_fire) - CW'(imem_rsp_valid);
    if (redirect_valid) begin
      // A response landing this cycle is already stale
      fetch_pc_n = target;
      rsp_pc_n   = target;
      discard_n  = outst - CW'(imem_rsp_valid);
      state_n    = (discard_n != '0) ? FETCH_FLUSH : FETCH_RUN;
    end else begin
      unique case (state)
        FETCH_RUN: begin
          if (req_fire) fetch_pc_n = fetch_pc + PC_STEP;
          if (rsp_wr)   rsp_pc_n   = rsp_pc + PC_STEP;
        end
        FETCH_FLUSH: begin
          if (imem_rsp_valid && discard != '0) begin
            discard_n = discard - 1'b1;
            if (discard_n == '0) state_n = FETCH_RUN;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= FETCH_RUN;
      fetch_pc <= RESET_PC;
      rsp_pc   <= RESET_PC;
      outst    <= '0;
      discard  <= '0;
    end else begin
      state    <= state_n;
      fetch_pc <= fetch_pc_n;
      rsp_pc   <= rsp_pc_n;
      outst    <= outst_n;
      discard  <= discard_n;
    end
  end

  fetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .clear    (redirect_valid),
    .wr_en    (rsp_wr),
    .wr_pc    (rsp_pc),
    .wr_instr (imem_rsp_data),
    .rd_en    (deliver),
    .rd_valid (instr_valid),
    .rd_pc    (instr_pc),
    .rd_instr (instruction),
    .count    (occ)
  );

`ifdef INSTR_FETCH_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_fetch_count <= '0;
      perf_flush_count <= '0;
    end else begin
      if (deliver)        perf_fetch_count <= perf_fetch_count + 1'b1;
      if (redirect_valid) perf_flush_count <= perf_flush_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with an in-order memory model
// and a delivery scoreboard.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = 32'h0;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instruction;
  logic [31:0] instr_pc;
`ifdef INSTR_FETCH_PERF_EN
  logic [31:0] perf_fetch_count;
  logic [31:0] perf_flush_count;
`endif

  always #5 clk = ~clk;

  instr_fetch dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instruction    (instruction),
    .instr_pc       (instr_pc)
`ifdef INSTR_FETCH_PERF_EN
    ,
    .perf_fetch_count (perf_fetch_count),
    .perf_flush_count (perf_flush_count)
`endif
  );

  typedef struct {
    int          due;
    logic [31:0] addr;
  } mreq_t;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          mem_lat = 1;
  int          deliv_cnt = 0;
  int          redir_cnt = 0;
  int          req_cnt = 0;
  logic [31:0] exp_req_addr = 32'h0;
  logic [31:0] mon_e;
  mreq_t       mem_q[$];
  logic [31:0] exp_q[$];

  function automatic logic [31:0] word_of(logic [31:0] a);
    logic [31:0] r;
    r = {a[15:0], ~a[31:16]} ^ 32'h3C5A_0F96;
    return r;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Memory response driver: one in-order response per cycle when due
  always @(posedge clk) begin
    cyc++;
    #1;
    if (mem_q.size() != 0 && mem_q[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = word_of(mem_q[0].addr);
      void'(mem_q.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
    end
  end

  // Monitor: request checks, memory capture, delivery scoreboard
  always @(negedge clk) begin
    if (reset) begin
      mem_q.delete();
      exp_q.delete();
      exp_req_addr = 32'h0;
      deliv_cnt = 0;
      redir_cnt = 0;
      req_cnt = 0;
    end else begin
      if (instr_valid && instr_ready) begin
        chk("sb_has_entry", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          chk("deliv_pc", instr_pc, mon_e);
          chk("deliv_word", instruction, word_of(mon_e));
        end
        deliv_cnt++;
      end
      if (redirect_valid) begin
        chk("redir_no_req", 32'(imem_req_valid), 32'd0);
        exp_q.delete();
        exp_req_addr = redirect_pc & 32'hFFFF_FFFC;
        redir_cnt++;
      end else if (imem_req_valid && imem_req_ready) begin
        chk("req_addr", imem_req_addr, exp_req_addr);
        exp_q.push_back(exp_req_addr);
        mem_q.push_back('{due: cyc + mem_lat, addr: imem_req_addr});
        exp_req_addr = exp_req_addr + 32'd4;
        req_cnt++;
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    redirect_valid = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("rst_instr_valid", 32'(instr_valid), 32'd0);
    chk("rst_instruction", instruction, 32'h0);
    chk("rst_instr_pc", instr_pc, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int drops;
    int found;
    reset = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    imem_req_ready = 1'b1;
    instr_ready = 1'b1;

    // Streaming, 1-cycle memory
    mem_lat = 1;
    do_reset();
    @(negedge clk);
    chk("a_req_valid", 32'(imem_req_valid), 32'd1);
    chk("a_req_addr", imem_req_addr, 32'h0);
    chk("a_valid_c1", 32'(instr_valid), 32'd0);
    @(negedge clk);
    chk("a_valid_c2", 32'(instr_valid), 32'd0);
    @(negedge clk);
    chk("a_valid_c3", 32'(instr_valid), 32'd1);
    chk("a_first_pc", instr_pc, 32'h0);
    repeat (20) @(posedge clk);
    #1;
    chk("a_deliv_cnt", deliv_cnt, 20);

    // Consumer stalled: credit fills the queue
    instr_ready = 1'b0;
    do_reset();
    repeat (10) @(posedge clk);
    #1;
    chk("b_req_cnt", req_cnt, 4);
    @(negedge clk);
    chk("b_req_stop", 32'(imem_req_valid), 32'd0);
    chk("b_valid", 32'(instr_valid), 32'd1);
    @(posedge clk); #1;
    instr_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("b_order", instr_pc, 32'(i * 4));
    end
    repeat (10) @(posedge clk);
    #1;

    // Redirect with 3 outstanding, 5-cycle memory
    mem_lat = 5;
    do_reset();
    repeat (3) @(posedge clk);
    #1;
    imem_req_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 32'h1003;
    @(negedge clk);
    chk("c_req_gated", 32'(imem_req_valid), 32'd0);
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    imem_req_ready = 1'b1;
    drops = 0;
    found = 0;
    for (int i = 0; i < 40 && found == 0; i++) begin
      @(negedge clk);
      if (imem_req_valid) found = 1;
      else if (imem_rsp_valid) drops++;
    end
    chk("c_req_resumed", found, 1);
    chk("c_drops", drops, 3);
    chk("c_next_addr", imem_req_addr, 32'h1000);
    found = 0;
    for (int i = 0; i < 40 && found == 0; i++) begin
      @(negedge clk);
      if (instr_valid) found = 1;
    end
    chk("c_deliv_seen", found, 1);
    chk("c_first_pc", instr_pc, 32'h1000);
    repeat (10) @(posedge clk);
    #1;

    // Redirect coinciding with response and delivery
    mem_lat = 1;
    do_reset();
    repeat (6) @(posedge clk);
    #1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h400;
    @(negedge clk);
    chk("d_delivery", 32'(instr_valid & instr_ready), 32'd1);
    chk("d_rsp", 32'(imem_rsp_valid), 32'd1);
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    @(negedge clk);
    chk("d_empty", 32'(instr_valid), 32'd0);
    chk("d_req_valid", 32'(imem_req_valid), 32'd1);
    chk("d_req_addr", imem_req_addr, 32'h400);
    repeat (8) @(posedge clk);
    #1;

    // Back-to-back redirects with deeper memory latency
    mem_lat = 3;
    repeat (4) @(posedge clk);
    #1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h200;
    @(posedge clk); #1;
    redirect_pc = 32'h300;
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    found = 0;
    for (int i = 0; i < 40 && found == 0; i++) begin
      @(negedge clk);
      if (instr_valid) found = 1;
    end
    chk("e_deliv_seen", found, 1);
    chk("e_first_pc", instr_pc, 32'h300);
    chk("e_first_word", instruction, word_of(32'h300));
    repeat (12) @(posedge clk);
    #1;

`ifdef INSTR_FETCH_PERF_EN
    instr_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("p_fetch_count", perf_fetch_count, deliv_cnt);
    chk("p_flush_count", perf_flush_count, redir_cnt);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, first fetch address after reset.
REQ-002 Parameter: DEPTH, 4, prefetch queue entries (power of two, 2..16).
REQ-003 Port: clk  in  1  single clock; all state updates on rising edge.
REQ-004 Port: reset  in  1  synchronous, active-high reset.
REQ-005 Port: imem_req_valid  out  1  fetch request valid.
REQ-006 Port: imem_req_ready  in  1  memory accepts request.
REQ-007 Port: imem_req_addr  out  32  word-aligned fetch address.
REQ-008 Port: imem_rsp_valid  in  1  response valid; responses return in request order, latency >=1.
REQ-009 Port: imem_rsp_data  in  32  fetched instruction word.
REQ-010 Port: redirect_valid  in  1  branch/jump redirect pulse.
REQ-011 Port: redirect_pc  in  32  new fetch address; bits [1:0] ignored (forced 0).
REQ-012 Port: instr_valid  out  1  instruction available to processor.
REQ-013 Port: instr_ready  in  1  processor consumes instruction.
REQ-014 Port: instruction  out  32  instruction word to processor (opcode in [31:26], immediate in [15:0]).
REQ-015 Port: instr_pc  out  32  address of the presented instruction.

Function
REQ-016 Transfers: request on imem_req_valid & imem_req_ready; delivery on instr_valid & instr_ready.
REQ-017 Fetch PC increments by 4 per accepted request; wraps 32'hFFFF_FFFC -> 0.
REQ-018 Credit: imem_req_valid = (state==RUN) & (occupancy + outstanding < DEPTH) & !redirect_valid; queue never overflows.
REQ-019 Each non-discarded response is written to the queue with its PC; instr_valid rises the cycle after the write (1-cycle latency, no bypass).
REQ-020 Queue empty -> instr_valid=0; simultaneous write and read on a full or empty queue preserves order and count.
REQ-021 FSM states: RUN (normal), FLUSH (discarding stale responses).
REQ-022 Redirect (any state): queue cleared, fetch PC <= {redirect_pc[31:2],2'b00}, discard count <= outstanding after accounting for any response in the same cycle (that response is dropped); next state FLUSH if discard count >0, else RUN.
REQ-023 FLUSH: each response decrements discard count and is dropped; no requests issued; count reaching 0 -> RUN next cycle.
REQ-024 Redirect priority: over request issue, response write and delivery in the same cycle; a delivery handshake in the redirect cycle is still valid for the consumer.
REQ-025 instruction/instr_pc stable while instr_valid & !instr_ready.

Reset
REQ-026 Reset: fetch PC=RESET_PC, queue empty, outstanding=0, discard=0, state RUN, instr_valid=0, imem_req_valid=0 during reset, instruction=0, instr_pc=0.
REQ-027 Reset mid-transaction: outstanding responses arriving after reset deassertion are not expected; memory is reset together with the block.

Configuration
REQ-028 Macro INSTR_FETCH_PERF_EN defined: adds outputs perf_fetch_count (32, deliveries) and perf_flush_count (32, redirects), both cleared by reset, wrapping at 2^32.
REQ-029 Macro undefined: those ports and counters are absent; all other behaviour identical.

Structure
REQ-030 Shared package proc_pkg holds XLEN=32, INSTR_W=32, PC_STEP=4 and the fetch-state enum (FETCH_RUN, FETCH_FLUSH).
REQ-031 Queue is a sub-module fetch_fifo (DEPTH entries of {pc, instruction}, registered outputs); control/FSM stays in instr_fetch.

Verification
REQ-032 Reset, memory 1-cycle latency, instr_ready=1 -> requests 0x0,0x4,0x8...; first instr_valid 3 cycles after reset release with instr_pc=0x0.
REQ-033 instr_ready=0, memory always ready -> exactly 4 requests (DEPTH=4), then imem_req_valid=0; queue holds PCs 0x0..0xC.
REQ-034 Redirect to 0x1003 with 3 outstanding, 5-cycle memory latency -> FLUSH, 3 responses dropped, next request addr 0x1000, first delivered instr_pc=0x1000.
REQ-035 Redirect coinciding with a response and a delivery -> response dropped, delivery counted, queue empty next cycle.
REQ-036 Back-to-back redirects (0x200 then 0x300) -> only 0x300-stream delivered; no stale word reaches instruction.
REQ-037 With INSTR_FETCH_PERF_EN, 10 deliveries and 2 redirects -> perf_fetch_count=10, perf_flush_count=2.
